pte_walk_arbiter: RTL and testbench

Shares one `PTEHelper` page-walk model between `NREQ` requesters, such as ITLB, DTLB load and DTLB store page-table walkers, in the simulation harness. Requests arrive on per-requester valid/ready channels. A round-robin arbiter picks one request. The block sequences a single one-cycle `enable` pulse to the helper, captures `pte`/`level`/`pf` into its own registers and returns them to the winning requester with backpressure. Only one walk is in flight at a time.

---
 rtl/pte_walk_arbiter.sv | 153 +++++++++++++++
 tb/tb_pte_walk_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pte_walk_arbiter.sv
// Round-robin share of one registered page-walk helper between NREQ requesters.
// Latency: accept T, helper_enable T+1, capture end of T+2, resp_valid from T+3.
// Backpressure: resp_ready low holds RESP with stable payload; no new accepts meanwhile.
module pte_walk_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [64*NREQ-1:0]   req_satp,
    input  logic [64*NREQ-1:0]   req_vpn,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [63:0]          resp_pte,
    output logic [7:0]           resp_level,
    output logic [7:0]           resp_pf,
    output logic                 helper_enable,
    output logic [63:0]          helper_satp,
    output logic [63:0]          helper_vpn,
    input  logic [63:0]          helper_pte,
    input  logic [7:0]           helper_level,
    input  logic [7:0]           helper_pf,
    output logic                 busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COLLECT = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef struct packed {
        logic [63:0] pte;
        logic [7:0]  level;
        logic [7:0]  pf;
    } walk_rsp_t;

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  rr_next;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W-1:0]  win_idx;
    logic              win_vld;
    logic              accept;
    logic [63:0]       win_satp;
    logic [63:0]       win_vpn;
    logic [63:0]       satp_q;
    logic [63:0]       vpn_q;
    walk_rsp_t         rsp_q;

    // Search starts at rr_ptr; candidate index is reduced modulo NREQ by one subtraction.
    always_comb begin
        logic [IDX_W:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NREQ)) begin
                cand = cand - (IDX_W+1)'(NREQ);
            end
            if (!win_vld && req_valid[cand[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        win_satp = '0;
        win_vpn  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_satp = req_satp[64*i +: 64];
                win_vpn  = req_vpn[64*i +: 64];
            end
        end
    end

    assign accept  = (state_q == IDLE) && win_vld;
    assign rr_next = (win_idx == IDX_W'(NREQ-1)) ? '0 : win_idx + IDX_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld) state_d = ISSUE;
            ISSUE:   state_d = COLLECT;
            COLLECT: state_d = RESP;
            RESP:    if (resp_ready[sel]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = '0;
        resp_valid    = '0;
        helper_enable = 1'b0;
        busy          = (state_q != IDLE);
        case (state_q)
            IDLE:    if (win_vld) req_ready = NREQ'(1) << win_idx;
            ISSUE:   helper_enable = 1'b1;
            RESP:    resp_valid = NREQ'(1) << sel;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
            sel    <= '0;
            satp_q <= '0;
            vpn_q  <= '0;
        end else if (accept) begin
            rr_ptr <= rr_next;
            sel    <= win_idx;
            satp_q <= win_satp;
            vpn_q  <= win_vpn;
        end
    end

    // Helper outputs are already registered one edge after enable, so COLLECT samples them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_q <= '0;
        end else if (state_q == COLLECT) begin
            rsp_q <= {helper_pte, helper_level, helper_pf};
        end
    end

    assign helper_satp = satp_q;
    assign helper_vpn  = vpn_q;
    assign resp_pte    = rsp_q.pte;
    assign resp_level  = rsp_q.level;
    assign resp_pf     = rsp_q.pf;

    a_req_ready_onehot: assert property (@(posedge clock) disable iff (!reset_n) $onehot0(req_ready));
    a_resp_valid_onehot: assert property (@(posedge clock) disable iff (!reset_n) $onehot0(resp_valid));
    a_enable_single: assert property (@(posedge clock) disable iff (!reset_n) helper_enable |=> !helper_enable);

endmodule

// File: tb/tb_pte_walk_arbiter.sv
// Scoreboard bench for pte_walk_arbiter with a transaction-level round-robin model
// and a behavioural page-walk helper.
module tb_pte_walk_arbiter;
    localparam int N = 4;

    typedef struct packed {
        logic [63:0] pte;
        logic [7:0]  level;
        logic [7:0]  pf;
    } walk_t;

    typedef struct {
        int          id;
        logic [63:0] satp;
        logic [63:0] vpn;
    } txn_t;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [64*N-1:0] req_satp;
    logic [64*N-1:0] req_vpn;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [63:0]     resp_pte;
    logic [7:0]      resp_level;
    logic [7:0]      resp_pf;
    logic            helper_enable;
    logic [63:0]     helper_satp;
    logic [63:0]     helper_vpn;
    logic [63:0]     helper_pte = '0;
    logic [7:0]      helper_level = '0;
    logic [7:0]      helper_pf = '0;
    logic            busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    pte_walk_arbiter #(.NREQ(N)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_satp(req_satp), .req_vpn(req_vpn),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_pte(resp_pte), .resp_level(resp_level), .resp_pf(resp_pf),
        .helper_enable(helper_enable), .helper_satp(helper_satp), .helper_vpn(helper_vpn),
        .helper_pte(helper_pte), .helper_level(helper_level), .helper_pf(helper_pf),
        .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Page-table behaviour: one fixed translation, vpn ending in F faults, otherwise a hash.
    function automatic walk_t walk_ref(input logic [63:0] satp, input logic [63:0] vpn);
        walk_t w;
        if (satp == 64'h8000_0000_0008_0000 && vpn == 64'h12345) begin
            w = '{pte: 64'h2000_04CF, level: 8'd1, pf: 8'd0};
        end else if (vpn[3:0] == 4'hF) begin
            w = '{pte: 64'd0, level: 8'd2, pf: 8'd1};
        end else begin
            w.pte   = (satp ^ (vpn << 10)) | 64'h1;
            w.level = {6'd0, vpn[5:4]};
            w.pf    = 8'd0;
        end
        return w;
    endfunction

    always @(posedge clock) begin
        if (helper_enable) {helper_pte, helper_level, helper_pf} <= walk_ref(helper_satp, helper_vpn);
    end

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            int i = (start + k) % N;
            if (v[i]) return N'(1) << i;
        end
        return '0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: transaction model of the arbiter plus scoreboard of accepted walks.
    int   m_rr = 0;
    bit   inflight = 1'b0;
    int   acc = 0;
    txn_t sb[$];

    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                chk("rst_req_ready", 64'(req_ready), 64'(rr_pick(req_valid, 0)));
                chk("rst_resp_valid", 64'(resp_valid), 64'd0);
                chk("rst_enable", 64'(helper_enable), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_pte", resp_pte, 64'd0);
                chk("rst_level_pf", {48'd0, resp_level, resp_pf}, 64'd0);
                chk("rst_helper_satp", helper_satp, 64'd0);
                chk("rst_helper_vpn", helper_vpn, 64'd0);
                m_rr = 0;
                inflight = 1'b0;
                sb.delete();
            end else begin
                logic [N-1:0] exp_rdy;
                logic [N-1:0] exp_rv;
                bit           exp_en;
                walk_t        w;
                int           id;
                exp_rdy = inflight ? '0 : rr_pick(req_valid, m_rr);
                chk("req_ready", 64'(req_ready), 64'(exp_rdy));
                chk("busy", 64'(busy), 64'(inflight));
                exp_en = inflight && (cyc == acc + 1);
                chk("helper_enable", 64'(helper_enable), 64'(exp_en));
                if (exp_en) begin
                    chk("helper_satp", helper_satp, sb[0].satp);
                    chk("helper_vpn", helper_vpn, sb[0].vpn);
                end
                exp_rv = (inflight && cyc >= acc + 3) ? (N'(1) << sb[0].id) : '0;
                chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
                if (exp_rv != '0) begin
                    w = walk_ref(sb[0].satp, sb[0].vpn);
                    chk("resp_pte", resp_pte, w.pte);
                    chk("resp_level", 64'(resp_level), 64'(w.level));
                    chk("resp_pf", 64'(resp_pf), 64'(w.pf));
                    if (resp_ready[sb[0].id]) begin
                        void'(sb.pop_front());
                        inflight = 1'b0;
                    end
                end
                if (exp_rdy != '0) begin
                    id = 0;
                    for (int i = 0; i < N; i++) if (exp_rdy[i]) id = i;
                    sb.push_back('{id: id, satp: req_satp[64*id +: 64], vpn: req_vpn[64*id +: 64]});
                    acc = cyc;
                    m_rr = (id + 1) % N;
                    inflight = 1'b1;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_rdy(input int id);
        bit got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clock);
            got = req_ready[id] & req_valid[id];
        end
        chk("accept_wait", 64'(got), 64'd1);
    endtask

    task automatic issue(input int id, input logic [63:0] s, input logic [63:0] v);
        req_satp[64*id +: 64] = s;
        req_vpn[64*id +: 64]  = v;
        req_valid = N'(1) << id;
        wait_rdy(id);
        @(posedge clock);
        #1 req_valid = '0;
    endtask

    initial begin
        reset_n = 1'b1;
        req_valid = '0;
        req_satp = '0;
        req_vpn = '0;
        resp_ready = '0;
        #1 reset_n = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1 req_valid = N'($urandom_range(0, 15));
        end
        @(posedge clock);
        #1 reset_n = 1'b1;
        req_valid = '0;
        resp_ready = '1;

        // Single request, then a fault; both hold resp_ready high
        issue(2, 64'h8000_0000_0008_0000, 64'h12345);
        idle(6);
        issue(0, 64'h8000_0000_0001_0000, 64'hABCDF);
        idle(6);

        // All requesters contend
        req_valid = '1;
        repeat (24) @(posedge clock);
        #1 req_valid = '0;
        idle(6);

        // Requester 1 stalled on resp_ready while 3 waits; stray readies on others
        resp_ready = 4'b1101;
        req_satp[64*1 +: 64] = 64'h8000_0000_0002_0000;
        req_vpn[64*1 +: 64]  = 64'h777;
        req_valid = 4'b0010;
        wait_rdy(1);
        @(posedge clock);
        #1 req_valid = 4'b1000;
        repeat (14) @(posedge clock);
        #1 resp_ready = '1;
        idle(8);
        req_valid = '0;
        idle(6);

        // Randomized traffic, random/stray readies, faults
        repeat (400) begin
            @(posedge clock);
            #1;
            for (int i = 0; i < N; i++) begin
                req_satp[64*i +: 64] = {$urandom, $urandom};
                req_vpn[64*i +: 64]  = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) req_vpn[64*i +: 4] = 4'hF;
            end
            req_valid  = N'($urandom_range(0, 15));
            resp_ready = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom_range(0, 15));
        end
        req_valid = '0;
        resp_ready = '1;
        idle(8);

        // Reset during COLLECT of requester 2's walk
        req_satp[64*2 +: 64] = 64'h8000_0000_0003_0000;
        req_vpn[64*2 +: 64]  = 64'h4321;
        req_valid = 4'b0100;
        wait_rdy(2);
        @(posedge clock);
        #1 req_valid = '0;
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("async_resp_valid", 64'(resp_valid), 64'd0);
        chk("async_enable", 64'(helper_enable), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_req_ready", 64'(req_ready), 64'd0);
        chk("async_pte", resp_pte, 64'd0);
        chk("async_helper_vpn", helper_vpn, 64'd0);
        @(posedge clock);
        #1 req_valid = 4'b1010;
        @(posedge clock);
        #1 reset_n = 1'b1;
        idle(12);
        req_valid = '0;
        idle(8);

        chk("final_busy", 64'(busy), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
